frame_swap_controller: RTL and testbench

//  Schedules the double-buffered render loop. Starts the drawing manager and

---
 rtl/frame_swap_controller.sv | 118 +++++++++++
 tb/tb_frame_swap_controller.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/frame_swap_controller.sv
`default_nettype none
// ============================================================================
//  Module   : frame_swap_controller
//  Purpose  : Double-buffer render-loop scheduler; swaps draw/display buffers
//             on vsync once a frame is done, and measures swaps per window.
//  Revision : 1.0 - initial release
// ============================================================================
module frame_swap_controller #(
  parameter int MIN_VSYNCS = 1,
  parameter int FPS_WINDOW = 60,
  parameter int FPS_WIDTH  = 8
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 enable,
  input  logic                 vsync,
  input  logic                 frame_done,
  output logic                 draw_start,
  output logic                 draw_ack,
  output logic                 draw_buffer_select,
  output logic                 disp_buffer_select,
  output logic [FPS_WIDTH-1:0] fps_count
);

  localparam int VSW = $clog2(MIN_VSYNCS + 1);
  localparam int WW  = (FPS_WINDOW > 1) ? $clog2(FPS_WINDOW) : 1;

  localparam logic [1:0] S_START   = 2'd0;
  localparam logic [1:0] S_DRAWING = 2'd1;
  localparam logic [1:0] S_WAIT    = 2'd2;
  localparam logic [1:0] S_SWAP    = 2'd3;

  localparam logic [VSW-1:0]       c_min_vs   = VSW'(MIN_VSYNCS);
  localparam logic [VSW:0]         c_min_ext  = (VSW+1)'(MIN_VSYNCS);
  localparam logic [WW-1:0]        c_win_last = WW'(FPS_WINDOW - 1);
  localparam logic [FPS_WIDTH-1:0] c_cnt_max  = '1;

  logic [1:0]           r_state;
  logic [1:0]           w_state_next;
  logic                 r_vsync_q;
  logic [VSW-1:0]       r_vs_since_swap;
  logic [WW-1:0]        r_win_cnt;
  logic [FPS_WIDTH-1:0] r_swap_cnt;
  logic [FPS_WIDTH-1:0] r_fps_count;
  logic                 r_draw_start;
  logic                 r_draw_ack;
  logic                 r_draw_sel;

  logic                 w_vsync_rise;
  logic [VSW:0]         w_vs_inc;
  logic                 w_swap_ok;
  logic                 w_in_swap;
  logic [FPS_WIDTH-1:0] w_swap_cnt_next;

  assign w_vsync_rise = vsync & ~r_vsync_q;
  // The +1 credits the rising edge happening in this very cycle.
  assign w_vs_inc     = {1'b0, r_vs_since_swap} + (VSW+1)'(1);
  assign w_swap_ok    = enable & w_vsync_rise & (w_vs_inc >= c_min_ext);
  assign w_in_swap    = (r_state == S_SWAP);

  assign w_swap_cnt_next = (w_in_swap && (r_swap_cnt != c_cnt_max)) ?
                           r_swap_cnt + FPS_WIDTH'(1) : r_swap_cnt;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_START:   w_state_next = S_DRAWING;
      S_DRAWING: if (frame_done) w_state_next = S_WAIT;
      S_WAIT:    if (w_swap_ok)  w_state_next = S_SWAP;
      S_SWAP:    w_state_next = S_DRAWING;
      default:   w_state_next = S_START;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state         <= S_START;
      r_vsync_q       <= 1'b0;
      r_vs_since_swap <= '0;
      r_win_cnt       <= '0;
      r_swap_cnt      <= '0;
      r_fps_count     <= '0;
      r_draw_start    <= 1'b0;
      r_draw_ack      <= 1'b0;
      r_draw_sel      <= 1'b1;
    end else begin
      r_state      <= w_state_next;
      r_vsync_q    <= vsync;
      r_draw_start <= (r_state == S_START);
      r_draw_ack   <= (r_state == S_WAIT) & w_swap_ok;

      if (w_in_swap) begin
        r_draw_sel      <= ~r_draw_sel;
        r_vs_since_swap <= w_vsync_rise ? VSW'(1) : '0;
      end else if (w_vsync_rise && (r_vs_since_swap != c_min_vs)) begin
        r_vs_since_swap <= r_vs_since_swap + VSW'(1);
      end

      // A swap landing on the window-closing edge belongs to the closing window.
      if (w_vsync_rise && (r_win_cnt == c_win_last)) begin
        r_fps_count <= w_swap_cnt_next;
        r_swap_cnt  <= '0;
        r_win_cnt   <= '0;
      end else begin
        r_swap_cnt <= w_swap_cnt_next;
        if (w_vsync_rise) r_win_cnt <= r_win_cnt + WW'(1);
      end
    end
  end

  assign draw_start         = r_draw_start;
  assign draw_ack           = r_draw_ack;
  assign draw_buffer_select = r_draw_sel;
  assign disp_buffer_select = ~r_draw_sel;
  assign fps_count          = r_fps_count;

endmodule
`default_nettype wire

// File: tb/tb_frame_swap_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_frame_swap_controller
//  Purpose  : Randomized bench for frame_swap_controller with an event-level
//             reference model; two instances (MIN_VSYNCS 1 and 2).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_frame_swap_controller;

  localparam int FPS_WIN = 4;
  localparam int MINV0   = 1;
  localparam int MINV1   = 2;
  localparam int P_START = 0, P_DRAW = 1, P_WAIT = 2, P_SWAP = 3;

  logic clk = 1'b0;
  logic rstn, enable, vsync;
  logic fd [2];
  logic ds [2], da [2], dsel [2], psel [2];
  logic [7:0] fps [2];

  always #5 clk = ~clk;

  frame_swap_controller #(.MIN_VSYNCS(MINV0), .FPS_WINDOW(FPS_WIN), .FPS_WIDTH(8)) u_dut0 (
    .clk(clk), .rstn(rstn), .enable(enable), .vsync(vsync), .frame_done(fd[0]),
    .draw_start(ds[0]), .draw_ack(da[0]), .draw_buffer_select(dsel[0]),
    .disp_buffer_select(psel[0]), .fps_count(fps[0]));

  frame_swap_controller #(.MIN_VSYNCS(MINV1), .FPS_WINDOW(FPS_WIN), .FPS_WIDTH(8)) u_dut1 (
    .clk(clk), .rstn(rstn), .enable(enable), .vsync(vsync), .frame_done(fd[1]),
    .draw_start(ds[1]), .draw_ack(da[1]), .draw_buffer_select(dsel[1]),
    .disp_buffer_select(psel[1]), .fps_count(fps[1]));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: state after the most recent clock edge.
  int m_st [2], m_since [2], m_win [2], m_swp [2], m_fps [2];
  bit m_vq [2], m_sel [2], m_start [2], m_ack [2];

  // Stimulus state
  int vcnt, vper, vmin, vmax, dmin, dmax, en_low;
  bit rnd_en;
  int cnt [2];
  bit linger [2];

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_st[i] = P_START; m_since[i] = 0; m_win[i] = 0; m_swp[i] = 0; m_fps[i] = 0;
      m_vq[i] = 0; m_sel[i] = 1; m_start[i] = 0; m_ack[i] = 0;
      cnt[i] = 0; linger[i] = 0; fd[i] = 0;
    end
  endtask

  task automatic model_step(input int i, input bit v, input bit en, input bit f);
    bit rise, ok, swapping;
    int nst, tmp, minv;
    minv     = (i == 0) ? MINV0 : MINV1;
    rise     = v && !m_vq[i];
    swapping = (m_st[i] == P_SWAP);
    ok       = en && rise && (m_since[i] + 1 >= minv);
    case (m_st[i])
      P_START: nst = P_DRAW;
      P_DRAW:  nst = f  ? P_WAIT : P_DRAW;
      P_WAIT:  nst = ok ? P_SWAP : P_WAIT;
      default: nst = P_DRAW;
    endcase
    m_start[i] = (m_st[i] == P_START);
    m_ack[i]   = (m_st[i] == P_WAIT) && ok;
    if (swapping) m_sel[i] = !m_sel[i];
    if (swapping)  m_since[i] = rise ? 1 : 0;
    else if (rise) m_since[i] = m_since[i] + 1;
    tmp = m_swp[i] + (swapping ? 1 : 0);
    if (tmp > 255) tmp = 255;
    if (rise) begin
      m_win[i] = m_win[i] + 1;
      if (m_win[i] == FPS_WIN) begin
        m_fps[i] = tmp;
        tmp      = 0;
        m_win[i] = 0;
      end
    end
    m_swp[i] = tmp;
    m_vq[i]  = v;
    m_st[i]  = nst;
  endtask

  task automatic check_outputs(input int i);
    check($sformatf("draw_start%0d", i), 32'(ds[i]),   32'(m_start[i]));
    check($sformatf("draw_ack%0d", i),   32'(da[i]),   32'(m_ack[i]));
    check($sformatf("draw_sel%0d", i),   32'(dsel[i]), 32'(m_sel[i]));
    check($sformatf("disp_sel%0d", i),   32'(psel[i]), 32'(!m_sel[i]));
    check($sformatf("fps%0d", i),        32'(fps[i]),  32'(m_fps[i]));
  endtask

  // One cycle, called at the falling edge: check, drive new inputs, advance model.
  task automatic do_cycle();
    for (int i = 0; i < 2; i++) check_outputs(i);
    rstn = 1'b1;
    if (rnd_en) begin
      if (en_low > 0) begin
        en_low--;
        enable = 1'b0;
      end else begin
        enable = 1'b1;
        if ($urandom_range(0, 99) == 0) en_low = $urandom_range(30, 60);
      end
    end else begin
      enable = 1'b1;
    end
    vsync = (vcnt < 2);
    vcnt++;
    if (vcnt >= vper) begin
      vcnt = 0;
      vper = $urandom_range(vmin, vmax);
    end
    // Drawing manager: frame_done held until ack, sometimes lingering into SWAP.
    for (int i = 0; i < 2; i++) begin
      if (m_start[i] || m_ack[i]) begin
        cnt[i] = $urandom_range(dmin, dmax);
        if (m_ack[i] && ($urandom_range(0, 2) == 0)) linger[i] = 1;
        else fd[i] = 1'b0;
      end else begin
        if (linger[i]) begin
          linger[i] = 0;
          fd[i] = 1'b0;
        end
        if (cnt[i] > 0) begin
          cnt[i]--;
          if (cnt[i] == 0) fd[i] = 1'b1;
        end
      end
    end
    for (int i = 0; i < 2; i++) model_step(i, vsync, enable, fd[i]);
  endtask

  initial begin
    bit found;
    rstn = 1'b0; enable = 1'b1; vsync = 1'b0;
    model_reset();
    vcnt = 0; vper = 10; en_low = 0;
    repeat (3) @(negedge clk);

    // Random frame times, vsync periods and enable gaps
    rnd_en = 1; vmin = 6; vmax = 16; dmin = 1; dmax = 25;
    for (int k = 0; k < 1500; k++) begin
      @(negedge clk);
      do_cycle();
    end

    // Fast drawing: one swap per vsync (MIN 1) vs one per two vsyncs (MIN 2)
    rnd_en = 0; en_low = 0; vmin = 10; vmax = 10; dmin = 1; dmax = 1;
    for (int k = 0; k < 900; k++) begin
      @(negedge clk);
      do_cycle();
    end
    check("fps_one_swap_per_vsync", 32'(fps[0]), 32'd4);
    check("fps_two_vsyncs_per_swap", 32'(fps[1]), 32'd2);

    // Asynchronous reset while waiting for vsync
    found = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      do_cycle();
      if (m_st[0] == P_WAIT) begin
        found = 1;
        break;
      end
    end
    check("reach_wait_vsync", 32'(found), 32'd1);
    if (found) begin
      @(posedge clk);
      #2 rstn = 1'b0;
      #1;
      for (int i = 0; i < 2; i++) begin
        check($sformatf("async_rst_start%0d", i), 32'(ds[i]),   32'd0);
        check($sformatf("async_rst_ack%0d", i),   32'(da[i]),   32'd0);
        check($sformatf("async_rst_draw%0d", i),  32'(dsel[i]), 32'd1);
        check($sformatf("async_rst_disp%0d", i),  32'(psel[i]), 32'd0);
        check($sformatf("async_rst_fps%0d", i),   32'(fps[i]),  32'd0);
      end
      model_reset();
    end

    rnd_en = 1; vmin = 6; vmax = 16; dmin = 1; dmax = 25;
    for (int k = 0; k < 500; k++) begin
      @(negedge clk);
      do_cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
